// File: rtl/init_handshake_v3.sv
// Serial-link init handshake: answers "UTN" with "UTNv<VER>\n", then takes a 16-bit
// sample rate (LSB first), answers "OK\n" or "ERROR\n" and publishes the decoded rate.
module init_handshake_v3 #(
    parameter logic [7:0]  VER_CHAR          = 8'h33,
    parameter int unsigned TIMEOUT_CYC       = 12_000_000,
    parameter int unsigned TO_W              = 24,
    parameter bit          ALLOW_BEST_EFFORT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rq_i,
    input  logic [7:0]  dato_rx_i,
    output logic        rx_st_o,
    output logic        tx_rq_o,
    output logic [7:0]  dato_tx_o,
    input  logic        tx_st_i,
    output logic [2:0]  tiempo_sel_o,
    output logic [15:0] samp_rate_o,
    output logic        best_effort_o,
    output logic        init_ok_o,
    output logic        init_err_o,
    output logic        timeout_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_T, S_HDR_N, S_SEND, S_RX_LO, S_RX_HI, S_CHECK
    } state_t;

    typedef enum logic [1:0] {M_HELLO, M_OK, M_ERR} msg_t;

    // Wraps harmlessly when TIMEOUT_CYC is 0; the counter never runs then.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_q, state_d;
    msg_t            msg_q, msg_d;
    logic [2:0]      idx_q, idx_d;
    logic            rx_rq_q, tx_st_q;
    logic            rx_st_q, rx_st_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            tx_rq_q, tx_rq_d;
    logic [7:0]      dato_tx_q, dato_tx_d;
    logic [15:0]     rate_tmp_q, rate_tmp_d;
    logic [2:0]      tiempo_sel_q, tiempo_sel_d;
    logic [15:0]     samp_rate_q, samp_rate_d;
    logic            best_effort_q, best_effort_d;
    logic            init_ok_q, init_ok_d;
    logic            init_err_q, init_err_d;
    logic            timeout_q, timeout_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic            rx_take, rx_latch, rx_state, to_run;
    logic [3:0]      rate_chk;

    function automatic logic [7:0] rom_byte(input msg_t m, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h0A;
        case (m)
            M_HELLO: case (i)
                3'd0:    b = 8'h55;
                3'd1:    b = 8'h54;
                3'd2:    b = 8'h4E;
                3'd3:    b = 8'h76;
                3'd4:    b = VER_CHAR;
                default: b = 8'h0A;
            endcase
            M_OK: case (i)
                3'd0:    b = 8'h4F;
                3'd1:    b = 8'h4B;
                default: b = 8'h0A;
            endcase
            M_ERR: case (i)
                3'd0:    b = 8'h45;
                3'd1:    b = 8'h52;
                3'd2:    b = 8'h52;
                3'd3:    b = 8'h4F;
                3'd4:    b = 8'h52;
                default: b = 8'h0A;
            endcase
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    function automatic logic [2:0] msg_last(input msg_t m);
        return (m == M_OK) ? 3'd2 : 3'd5;
    endfunction

    // Returns {valid, rate index}.
    function automatic logic [3:0] decode_rate(input logic [15:0] r);
        logic [3:0] res;
        case (r)
            16'd8000:  res = 4'b1000;
            16'd11025: res = 4'b1001;
            16'd16000: res = 4'b1010;
            16'd22050: res = 4'b1011;
            16'd24000: res = 4'b1100;
            16'd32000: res = 4'b1101;
            16'd44100: res = 4'b1110;
            16'd48000: res = 4'b1111;
            16'd0:     res = {ALLOW_BEST_EFFORT, 3'd0};
            default:   res = 4'b0000;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            msg_q         <= M_HELLO;
            idx_q         <= 3'd0;
            rx_rq_q       <= 1'b0;
            tx_st_q       <= 1'b0;
            rx_st_q       <= 1'b0;
            rx_byte_q     <= 8'h00;
            tx_rq_q       <= 1'b0;
            dato_tx_q     <= 8'h00;
            rate_tmp_q    <= 16'h0000;
            tiempo_sel_q  <= 3'd0;
            samp_rate_q   <= 16'h0000;
            best_effort_q <= 1'b0;
            init_ok_q     <= 1'b0;
            init_err_q    <= 1'b0;
            timeout_q     <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            msg_q         <= msg_d;
            idx_q         <= idx_d;
            rx_rq_q       <= rx_rq_i;
            tx_st_q       <= tx_st_i;
            rx_st_q       <= rx_st_d;
            rx_byte_q     <= rx_byte_d;
            tx_rq_q       <= tx_rq_d;
            dato_tx_q     <= dato_tx_d;
            rate_tmp_q    <= rate_tmp_d;
            tiempo_sel_q  <= tiempo_sel_d;
            samp_rate_q   <= samp_rate_d;
            best_effort_q <= best_effort_d;
            init_ok_q     <= init_ok_d;
            init_err_q    <= init_err_d;
            timeout_q     <= timeout_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        msg_d         = msg_q;
        idx_d         = idx_q;
        rx_st_d       = rx_st_q;
        rx_byte_d     = rx_byte_q;
        tx_rq_d       = tx_rq_q;
        dato_tx_d     = dato_tx_q;
        rate_tmp_d    = rate_tmp_q;
        tiempo_sel_d  = tiempo_sel_q;
        samp_rate_d   = samp_rate_q;
        best_effort_d = best_effort_q;
        init_ok_d     = init_ok_q;
        init_err_d    = init_err_q;
        timeout_d     = 1'b0;
        rx_take       = 1'b0;
        rx_latch      = 1'b0;
        rate_chk      = decode_rate(rate_tmp_q);
        rx_state      = (state_q == S_IDLE) || (state_q == S_HDR_T) || (state_q == S_HDR_N) ||
                        (state_q == S_RX_LO) || (state_q == S_RX_HI);
        to_run        = ((state_q == S_HDR_T) || (state_q == S_HDR_N) ||
                         (state_q == S_RX_LO) || (state_q == S_RX_HI)) &&
                        !rx_st_q && (TIMEOUT_CYC != 0);

        // Bytes are only accepted in listening states; a request arriving during SEND waits.
        if (rx_st_q && !rx_rq_q) begin
            rx_st_d = 1'b0;
            rx_take = 1'b1;
        end else if (!rx_st_q && rx_rq_q && rx_state) begin
            rx_st_d   = 1'b1;
            rx_byte_d = dato_rx_i;
            rx_latch  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_take && rx_byte_q == 8'h55) state_d = S_HDR_T;
            end
            S_HDR_T: begin
                if (rx_take) begin
                    if (rx_byte_q == 8'h54)      state_d = S_HDR_N;
                    else if (rx_byte_q == 8'h55) state_d = S_HDR_T;
                    else                         state_d = S_IDLE;
                end
            end
            S_HDR_N: begin
                if (rx_take) begin
                    if (rx_byte_q == 8'h4E) begin
                        state_d    = S_SEND;
                        msg_d      = M_HELLO;
                        idx_d      = 3'd0;
                        init_ok_d  = 1'b0;
                        init_err_d = 1'b0;
                    end else if (rx_byte_q == 8'h55) begin
                        state_d = S_HDR_T;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_SEND: begin
                if (!tx_rq_q && !tx_st_q) begin
                    tx_rq_d   = 1'b1;
                    dato_tx_d = rom_byte(msg_q, idx_q);
                end else if (tx_rq_q && tx_st_q) begin
                    tx_rq_d = 1'b0;
                    if (idx_q == msg_last(msg_q)) begin
                        idx_d = 3'd0;
                        case (msg_q)
                            M_HELLO: state_d = S_RX_LO;
                            M_OK: begin
                                init_ok_d = 1'b1;
                                state_d   = S_IDLE;
                            end
                            default: begin
                                init_err_d = 1'b1;
                                state_d    = S_IDLE;
                            end
                        endcase
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_RX_LO: begin
                if (rx_take) begin
                    rate_tmp_d[7:0] = rx_byte_q;
                    state_d         = S_RX_HI;
                end
            end
            S_RX_HI: begin
                if (rx_take) begin
                    rate_tmp_d[15:8] = rx_byte_q;
                    state_d          = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_SEND;
                idx_d   = 3'd0;
                if (rate_chk[3]) begin
                    samp_rate_d   = rate_tmp_q;
                    tiempo_sel_d  = rate_chk[2:0];
                    best_effort_d = (rate_tmp_q == 16'd0);
                    msg_d         = M_OK;
                end else begin
                    msg_d = M_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (to_run && !rx_latch && to_cnt_q == TO_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end

        to_cnt_d = to_run ? to_cnt_q + TO_W'(1) : '0;
        if (rx_latch || state_d != state_q) to_cnt_d = '0;
    end

    assign rx_st_o       = rx_st_q;
    assign tx_rq_o       = tx_rq_q;
    assign dato_tx_o     = dato_tx_q;
    assign tiempo_sel_o  = tiempo_sel_q;
    assign samp_rate_o   = samp_rate_q;
    assign best_effort_o = best_effort_q;
    assign init_ok_o     = init_ok_q;
    assign init_err_o    = init_err_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule
